// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the EXE stage.
// Results are computed when an op is accepted, held in pending registers, and
// committed to HI/LO after a fixed per-op latency; busy covers that whole window.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_NOP   = 3'b111
   } mdOp_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   mdOp_e            opIn;
   state_e           state, stateNext;
   logic [CNT_W-1:0] count, countNext;
   logic [31:0]      pendHi, pendLo;
   logic [63:0]      result;
   logic             loadPending, commit, writeHi, writeLo;

   logic [63:0]      prodSigned, prodUnsigned;
   logic             divSigned, divByZero, negQuot, negRem;
   logic [31:0]      magA, magB, divisor, quotMag, remMag, quot, rem;

   assign opIn = mdOp_e'(md_op);
   assign busy = (state == RUN);

   // Datapath: full 64-bit result for whichever mult/div op is presented this cycle.
   // Division works on magnitudes and restores signs afterwards; this also yields
   // 0x80000000 for the 0x80000000 / -1 overflow case without special handling.
   always_comb begin
      prodSigned   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      prodUnsigned = {32'h0, src_a} * {32'h0, src_b};

      divSigned = (opIn == OP_DIV);
      divByZero = (src_b == '0);
      divisor   = divByZero ? 32'd1 : src_b;
      magA      = (divSigned && src_a[31])   ? (~src_a + 32'd1)   : src_a;
      magB      = (divSigned && divisor[31]) ? (~divisor + 32'd1) : divisor;
      quotMag   = magA / magB;
      remMag    = magA % magB;
      negQuot   = divSigned && (src_a[31] ^ divisor[31]);
      negRem    = divSigned && src_a[31];
      quot      = negQuot ? (~quotMag + 32'd1) : quotMag;
      rem       = negRem  ? (~remMag + 32'd1)  : remMag;

      case (opIn)
         OP_MULT:  result = prodSigned;
         OP_MULTU: result = prodUnsigned;
         default:  result = divByZero ? {src_a, 32'hFFFF_FFFF} : {rem, quot};
      endcase
   end

   // Next-state and control: accept ops only in IDLE, count down latency in RUN.
   always_comb begin
      stateNext   = state;
      countNext   = count;
      loadPending = 1'b0;
      commit      = 1'b0;
      writeHi     = 1'b0;
      writeLo     = 1'b0;
      case (state)
         IDLE: begin
            case (opIn)
               OP_MULT, OP_MULTU: begin
                  loadPending = 1'b1;
                  countNext   = CNT_W'(MULT_CYCLES);
                  stateNext   = RUN;
               end
               OP_DIV, OP_DIVU: begin
                  loadPending = 1'b1;
                  countNext   = CNT_W'(DIV_CYCLES);
                  stateNext   = RUN;
               end
               OP_MTHI: writeHi = 1'b1;
               OP_MTLO: writeLo = 1'b1;
               default: ;
            endcase
         end
         RUN: begin
            if (count == CNT_W'(1)) begin
               commit    = 1'b1;
               countNext = '0;
               stateNext = IDLE;
            end else begin
               countNext = count - CNT_W'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State and latency counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= stateNext;
         count <= countNext;
      end
   end

   // Pending result capture and HI/LO update (commit or mthi/mtlo).
   always_ff @(posedge clk) begin
      if (reset) begin
         pendHi <= '0;
         pendLo <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (loadPending) begin
            pendHi <= result[63:32];
            pendLo <= result[31:0];
         end
         if (commit) begin
            hi <= pendHi;
            lo <= pendLo;
         end else begin
            if (writeHi) hi <= src_a;
            if (writeLo) lo <= src_a;
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit latency, arithmetic, mthi/mtlo and reset abort.
module tb_md_unit;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_NOP   = 3'b111;

   localparam int NMUL = 4;
   localparam logic [2:0]  MUL_OP [NMUL] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
   localparam logic [31:0] MUL_A  [NMUL] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [31:0] MUL_B  [NMUL] = '{32'h0000_0003, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [31:0] MUL_HI [NMUL] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE};
   localparam logic [31:0] MUL_LO [NMUL] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0000_0001, 32'h0000_0001};

   localparam int NDIV = 7;
   localparam logic [2:0]  DIV_OP [NDIV] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIVU};
   localparam logic [31:0] DIV_A  [NDIV] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h0000_0007, 32'h8000_0000,
                                             32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0000_0005};
   localparam logic [31:0] DIV_B  [NDIV] = '{32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                             32'h0000_0000, 32'h0000_0010, 32'h0000_0000};
   localparam logic [31:0] DIV_HI [NDIV] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                                             32'hFFFF_FFF9, 32'h0000_000F, 32'h0000_0005};
   localparam logic [31:0] DIV_LO [NDIV] = '{32'hFFFF_FFFD, 32'h0000_0003, 32'hFFFF_FFFD, 32'h8000_0000,
                                             32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hFFFF_FFFF};

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  md_op;
   logic [31:0] srcA, srcB;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   md_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .md_op(md_op),
      .src_a(srcA),
      .src_b(srcB),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; md_op = OP_NONE; srcA = '0; srcB = '0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL reset: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
      end
      reset = 1'b0;
   endtask

   task automatic test_mult();
      for (int v = 0; v < NMUL; v++) begin
         @(negedge clk);
         md_op = MUL_OP[v]; srcA = MUL_A[v]; srcB = MUL_B[v];
         @(negedge clk);
         md_op = OP_NONE; srcA = '0; srcB = '0;
         for (int c = 1; c <= 5; c++) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL mult[%0d] busy cycle %0d: busy=%b, required 1", v, c, busy);
            end
            @(negedge clk);
         end
         vectors++;
         if (busy !== 1'b0 || hi !== MUL_HI[v] || lo !== MUL_LO[v]) begin
            miscompares++;
            $display("FAIL mult[%0d] result: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                     v, busy, hi, lo, MUL_HI[v], MUL_LO[v]);
         end
      end
   endtask

   task automatic test_div();
      for (int v = 0; v < NDIV; v++) begin
         @(negedge clk);
         md_op = DIV_OP[v]; srcA = DIV_A[v]; srcB = DIV_B[v];
         @(negedge clk);
         md_op = OP_NONE; srcA = '0; srcB = '0;
         for (int c = 1; c <= 10; c++) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL div[%0d] busy cycle %0d: busy=%b, required 1", v, c, busy);
            end
            @(negedge clk);
         end
         vectors++;
         if (busy !== 1'b0 || hi !== DIV_HI[v] || lo !== DIV_LO[v]) begin
            miscompares++;
            $display("FAIL div[%0d] result: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                     v, busy, hi, lo, DIV_HI[v], DIV_LO[v]);
         end
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] prevLo;
      prevLo = DIV_LO[NDIV-1];
      @(negedge clk);
      md_op = OP_MTHI; srcA = 32'h0000_1234; srcB = 32'h0000_DEAD;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== prevLo) begin
         miscompares++;
         $display("FAIL mthi: busy=%b hi=%h lo=%h, required busy=0 hi=00001234 lo=%h", busy, hi, lo, prevLo);
      end
      md_op = OP_MTLO; srcA = 32'h0000_5678;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
         miscompares++;
         $display("FAIL mtlo: busy=%b hi=%h lo=%h, required busy=0 hi=00001234 lo=00005678", busy, hi, lo);
      end
      md_op = OP_NOP; srcA = 32'h0000_9999; srcB = 32'h0000_0001;
      @(negedge clk);
      md_op = OP_NONE;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
         miscompares++;
         $display("FAIL nop: busy=%b hi=%h lo=%h, required busy=0 hi=00001234 lo=00005678", busy, hi, lo);
      end
   endtask

   task automatic test_mult_with_mthi();
      @(negedge clk);
      md_op = OP_MULT; srcA = 32'h0000_0010; srcB = 32'h0000_0020;
      @(negedge clk);
      md_op = OP_NONE; srcA = '0; srcB = '0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 3) begin
            md_op = OP_MTHI; srcA = 32'h0000_00AA;
         end else begin
            md_op = OP_NONE; srcA = '0;
         end
         vectors++;
         if (busy !== 1'b1 || hi !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL mult+mthi busy cycle %0d: busy=%b hi=%h, required busy=1 hi=00001234", c, busy, hi);
         end
         @(negedge clk);
      end
      md_op = OP_NONE; srcA = '0;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL mult+mthi result: busy=%b hi=%h lo=%h, required busy=0 hi=00000000 lo=00000200", busy, hi, lo);
      end
      @(negedge clk);
      vectors++;
      if (hi !== 32'h0 || lo !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL mult+mthi hold: hi=%h lo=%h, required hi=00000000 lo=00000200", hi, lo);
      end
   endtask

   task automatic test_div_reset();
      @(negedge clk);
      md_op = OP_DIV; srcA = 32'd100; srcB = 32'd7;
      @(negedge clk);
      md_op = OP_NONE; srcA = '0; srcB = '0;
      for (int c = 1; c <= 4; c++) begin
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL div-reset busy cycle %0d: busy=%b, required 1", c, busy);
         end
         if (c == 4) reset = 1'b1;
         @(negedge clk);
      end
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL div-reset abort: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++;
            $display("FAIL div-reset late commit %0d: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0",
                     c, busy, hi, lo);
         end
      end
   endtask

   initial begin
      reset = 1'b1; md_op = OP_NONE; srcA = '0; srcB = '0;
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_mult_with_mthi();
      test_div_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
